jtframe_prog_packer: RTL

ROM-download packer between the MiST I/O controller's byte stream (`ioctl_*`) and the SDRAM programming port (`prog_*`) of the frame.
- Strips an optional file header and maps byte addresses onto one of four SDRAM banks.
- Packs consecutive bytes into 16-bit words with byte masks.
- Buffers packed words in a small FIFO and issues them to the SDRAM controller with a `prog_we`/`prog_rdy` handshake.
- Drives `dwnld_busy` so the game stays in reset until the last word is written.

---
 rtl/jtframe_prog_pkg.sv | 35 +++
 rtl/jtframe_prog_packer_if.sv | 21 ++
 rtl/jtframe_prog_fifo.sv | 48 ++++
 rtl/jtframe_prog_packer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/jtframe_prog_pkg.sv
// rtl/jtframe_prog_pkg.sv - shared types and constants for the ROM-download packer
package jtframe_prog_pkg;

    // Widest word address a packed word can carry; the top slices it to SDRAMW
    localparam int ADDRW_MAX = 26;

    // Active-low byte enables, bit 0 is the low byte
    localparam logic [1:0] MASK_FULL = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    typedef struct packed {
        logic [1:0]           ba;
        logic [ADDRW_MAX-1:0] addr;
        logic [15:0]          data;
        logic [1:0]           mask;
    } prog_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } issue_state_t;

    function automatic prog_word_t pack_word(input logic [1:0] ba, input logic [ADDRW_MAX-1:0] addr,
                                             input logic [15:0] data, input logic [1:0] mask);
        prog_word_t w;
        w.ba   = ba;
        w.addr = addr;
        w.data = data;
        w.mask = mask;
        return w;
    endfunction

endpackage

// File: rtl/jtframe_prog_packer_if.sv
// rtl/jtframe_prog_packer_if.sv - SDRAM programming-port bundle
interface jtframe_prog_packer_if #(
    parameter int SDRAMW = 22
);
    logic [SDRAMW-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [1:0]        prog_mask;
    logic [1:0]        prog_ba;
    logic              prog_we;
    logic              prog_rdy;

    modport master (
        output prog_addr, prog_data, prog_mask, prog_ba, prog_we,
        input  prog_rdy
    );

    modport slave (
        input  prog_addr, prog_data, prog_mask, prog_ba, prog_we,
        output prog_rdy
    );
endinterface

// File: rtl/jtframe_prog_fifo.sv
// rtl/jtframe_prog_fifo.sv - first-word-fall-through FIFO of packed program words
module jtframe_prog_fifo
    import jtframe_prog_pkg::*;
#(
    parameter int FIFOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  prog_word_t din_i,
    input  logic       pop_i,
    output prog_word_t dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);
    localparam int DEPTH = 1 << FIFOW;

    prog_word_t       mem_q [DEPTH];
    logic [FIFOW:0]   wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[FIFOW] != rd_ptr_q[FIFOW]) &&
                     (wr_ptr_q[FIFOW-1:0] == rd_ptr_q[FIFOW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push while full still lands
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign dout_o  = mem_q[rd_ptr_q[FIFOW-1:0]];

    // Storage write and pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[FIFOW-1:0]] <= din_i;
                wr_ptr_q <= wr_ptr_q + (FIFOW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (FIFOW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/jtframe_prog_packer.sv
// rtl/jtframe_prog_packer.sv - ioctl byte stream to SDRAM programming-port packer
module jtframe_prog_packer
    import jtframe_prog_pkg::*;
#(
    parameter int          SDRAMW    = 22,
    parameter int unsigned HEADER    = 0,
    parameter logic [25:0] BA1_START = 26'h100_0000,
    parameter logic [25:0] BA2_START = 26'h200_0000,
    parameter logic [25:0] BA3_START = 26'h300_0000,
    parameter int          FIFOW     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [25:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    input  logic                  ioctl_wr,
    jtframe_prog_packer_if.master prog,
    output logic                  dwnld_busy,
    output logic                  ovf
);
    localparam logic [25:0] HDR = 26'(HEADER);

    logic              acc, rise, fall, pv, match;
    logic [25:0]       eff, off;
    logic [1:0]        ba;
    logic [SDRAMW-1:0] waddr;

    logic              dl_q, part_valid_q, part_valid_d, push_q, push_d, stale_d, ovf_q;
    logic [1:0]        part_ba_q, part_ba_d;
    logic [SDRAMW-1:0] part_addr_q, part_addr_d;
    logic [7:0]        part_lo_q, part_lo_d;
    prog_word_t        push_word_q, push_word_d;

    logic              fifo_pop, fifo_full, fifo_empty, fifo_drop;
    prog_word_t        fifo_head;

    issue_state_t      state_q;
    logic              we_q;
    logic [SDRAMW-1:0] addr_q;
    logic [15:0]       data_q;
    logic [1:0]        mask_q, ba_q;
    logic              unused_bits;

    assign acc   = ioctl_wr & downloading & (ioctl_addr >= HDR);
    assign eff   = ioctl_addr - HDR;
    assign rise  = downloading & ~dl_q;
    assign fall  = ~downloading & dl_q;
    // A rising download edge invalidates the partial even for a byte in the same cycle
    assign pv    = part_valid_q & ~rise;
    assign waddr = off[SDRAMW:1];
    assign match = pv && (part_ba_q == ba) && (part_addr_q == waddr);

    // Bank selection: highest region whose start the address has reached
    always_comb begin
        ba  = 2'd0;
        off = eff;
        if (eff >= BA3_START) begin
            ba  = 2'd3;
            off = eff - BA3_START;
        end else if (eff >= BA2_START) begin
            ba  = 2'd2;
            off = eff - BA2_START;
        end else if (eff >= BA1_START) begin
            ba  = 2'd1;
            off = eff - BA1_START;
        end
    end

    // Packer next state: at most one word pushed per accepted byte or falling edge
    always_comb begin
        part_valid_d = part_valid_q;
        part_ba_d    = part_ba_q;
        part_addr_d  = part_addr_q;
        part_lo_d    = part_lo_q;
        push_d       = 1'b0;
        push_word_d  = push_word_q;
        stale_d      = 1'b0;
        if (rise) begin
            part_valid_d = 1'b0;
        end
        if (fall && part_valid_q) begin
            push_d       = 1'b1;
            push_word_d  = pack_word(part_ba_q, ADDRW_MAX'(part_addr_q), {part_lo_q, part_lo_q}, MASK_LO);
            part_valid_d = 1'b0;
        end else if (acc) begin
            if (!eff[0]) begin
                if (pv) begin
                    push_d      = 1'b1;
                    push_word_d = pack_word(part_ba_q, ADDRW_MAX'(part_addr_q), {part_lo_q, part_lo_q}, MASK_LO);
                end
                part_valid_d = 1'b1;
                part_ba_d    = ba;
                part_addr_d  = waddr;
                part_lo_d    = ioctl_dout;
            end else if (match) begin
                push_d       = 1'b1;
                push_word_d  = pack_word(ba, ADDRW_MAX'(waddr), {ioctl_dout, part_lo_q}, MASK_FULL);
                part_valid_d = 1'b0;
            end else begin
                push_d       = 1'b1;
                push_word_d  = pack_word(ba, ADDRW_MAX'(waddr), {ioctl_dout, ioctl_dout}, MASK_HI);
                part_valid_d = 1'b0;
                stale_d      = pv;
            end
        end
    end

    // Packer registers, push stage and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_q         <= 1'b0;
            part_valid_q <= 1'b0;
            part_ba_q    <= 2'd0;
            part_addr_q  <= '0;
            part_lo_q    <= 8'd0;
            push_q       <= 1'b0;
            push_word_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            dl_q         <= downloading;
            part_valid_q <= part_valid_d;
            part_ba_q    <= part_ba_d;
            part_addr_q  <= part_addr_d;
            part_lo_q    <= part_lo_d;
            push_q       <= push_d;
            push_word_q  <= push_word_d;
            ovf_q        <= ovf_q | stale_d | fifo_drop;
        end
    end

    jtframe_prog_fifo #(.FIFOW(FIFOW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .din_i   (push_word_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign fifo_pop = (state_q == ST_WAIT) & prog.prog_rdy;

    // Issuer: latch the FIFO head onto the bus and hold it until the controller acknowledges
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 16'd0;
            mask_q  <= MASK_NONE;
            ba_q    <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        addr_q  <= fifo_head.addr[SDRAMW-1:0];
                        data_q  <= fifo_head.data;
                        mask_q  <= fifo_head.mask;
                        ba_q    <= fifo_head.ba;
                        we_q    <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (prog.prog_rdy) begin
                        we_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign prog.prog_we   = we_q;
    assign prog.prog_addr = addr_q;
    assign prog.prog_data = data_q;
    assign prog.prog_mask = mask_q;
    assign prog.prog_ba   = ba_q;

    // The push stage counts as pending work so busy has no gap between packer and FIFO
    assign dwnld_busy = downloading | part_valid_q | push_q | ~fifo_empty | we_q;
    assign ovf        = ovf_q;

    assign unused_bits = ^{off[0], off[25:SDRAMW+1], fifo_head.addr[ADDRW_MAX-1:SDRAMW], fifo_full};
endmodule
